decode_pipe: RTL and testbench

Parametrised decode stage for the pipelined MIPS core: register file with write-through bypass, immediate extension, N-source forwarding into the branch comparator, next-PC resolution, and the registered D/E pipeline boundary with hold/bubble/flush control. Sits between the F/D register and the execute stage. It succeeds the fixed 32-bit, three-source decode stage.

---
 rtl/decode_pkg.sv | 31 +++
 rtl/decode_pipe_grf_bypass.sv | 38 +++
 rtl/decode_pipe.sv | 174 +++++++++++++++++
 tb/tb_decode_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings for the decode stage (next-PC select, extension op, exception codes, compare flags).
package decode_pkg;

    typedef enum logic [2:0] {
        NPC_PC4       = 3'd0,
        NPC_BEQ       = 3'd1,
        NPC_BNE       = 3'd2,
        NPC_BLEZ      = 3'd3,
        NPC_BGTZ      = 3'd4,
        NPC_BLTZ_BGEZ = 3'd5,
        NPC_J         = 3'd6,
        NPC_JR        = 3'd7
    } npc_sel_e;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2,
        EXT_RSVD = 2'd3
    } ext_op_e;

    localparam int EXC_RI = 10;

    localparam int CMP_EQ  = 0;
    localparam int CMP_LEZ = 1;
    localparam int CMP_GTZ = 2;
    localparam int CMP_LTZ = 3;
    localparam int CMP_GEZ = 4;
    localparam int CMP_W   = 5;

endpackage

// File: rtl/decode_pipe_grf_bypass.sv
// grf_bypass: NREG x XLEN register file, two combinational read ports with write-through, one write port.
module grf_bypass #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] rd1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && wa != '0)
            regs_d[wa] = wd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            regs_q <= '{default: '0};
        else
            regs_q <= regs_d;
    end

    // r0 wins over the bypass so a write to r0 never leaks into a read
    assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs_q[ra2];

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: MIPS decode stage - register read with bypass, forwarding, immediate extension,
// branch compare / next-PC resolution and the D/E pipeline register with hold/bubble/flush.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NFWD = 3,
    parameter int EXCW = 5,
    localparam int AW = $clog2(NREG),
    localparam int FW = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_d,
    input  logic [31:0]          instr_d,
    input  logic [XLEN-1:0]      pc_d,
    input  logic [EXCW-1:0]      exc_d,
    input  logic                 legal_ir,
    input  logic [1:0]           ext_op,
    input  logic [2:0]           npc_sel,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [FW-1:0]        fwd_sel_rs,
    input  logic [FW-1:0]        fwd_sel_rt,
    input  logic                 wr_en_w,
    input  logic [AW-1:0]        wr_addr_w,
    input  logic [XLEN-1:0]      wr_data_w,
    input  logic                 hold_e,
    input  logic                 bubble_e,
    input  logic                 flush,
    output logic [XLEN-1:0]      npc,
    output logic                 br_taken,
    output logic [XLEN-1:0]      rs_e,
    output logic [XLEN-1:0]      rt_e,
    output logic [XLEN-1:0]      ext_e,
    output logic [XLEN-1:0]      pc_e,
    output logic [31:0]          instr_e,
    output logic [EXCW-1:0]      exc_e,
    output logic                 valid_e
);

    logic [XLEN-1:0] grf_rs, grf_rt, op_a, op_b;
    logic [XLEN-1:0] ext_val, sext_imm, pc4, br_tgt, j_tgt, tgt;
    logic [CMP_W-1:0] cmp;
    logic [EXCW-1:0] exc;
    logic [15:0] imm16;
    logic taken;
    npc_sel_e sel;
    ext_op_e ext_k;

    logic [XLEN-1:0] rs_e_d, rs_e_q, rt_e_d, rt_e_q, ext_e_d, ext_e_q, pc_e_d, pc_e_q;
    logic [31:0] instr_e_d, instr_e_q;
    logic [EXCW-1:0] exc_e_d, exc_e_q;
    logic valid_e_d, valid_e_q;

    grf_bypass #(.NREG(NREG), .XLEN(XLEN)) u_grf (
        .clk  (clk),
        .reset(reset),
        .we   (wr_en_w),
        .wa   (wr_addr_w),
        .wd   (wr_data_w),
        .ra1  (AW'(instr_d[25:21])),
        .rd1  (grf_rs),
        .ra2  (AW'(instr_d[20:16])),
        .rd2  (grf_rt)
    );

    // select 0 is the register file; any select past NFWD falls through to 0
    always_comb begin
        op_a = (fwd_sel_rs == '0) ? grf_rs : '0;
        op_b = (fwd_sel_rt == '0) ? grf_rt : '0;
        for (int k = 1; k <= NFWD; k++) begin
            if (fwd_sel_rs == FW'(k))
                op_a = fwd_data[(k-1)*XLEN +: XLEN];
            if (fwd_sel_rt == FW'(k))
                op_b = fwd_data[(k-1)*XLEN +: XLEN];
        end
    end

    assign imm16    = instr_d[15:0];
    assign ext_k    = ext_op_e'(ext_op);
    assign sext_imm = {{(XLEN-16){imm16[15]}}, imm16};
    assign ext_val  = (ext_k == EXT_SIGN) ? sext_imm :
                      (ext_k == EXT_LUI)  ? XLEN'({imm16, 16'h0000}) :
                      (ext_k == EXT_ZERO) ? XLEN'(imm16) : '0;

    assign cmp[CMP_EQ]  = (op_a == op_b);
    assign cmp[CMP_LTZ] = op_a[XLEN-1];
    assign cmp[CMP_LEZ] = op_a[XLEN-1] | ~|op_a;
    assign cmp[CMP_GTZ] = ~cmp[CMP_LEZ];
    assign cmp[CMP_GEZ] = ~cmp[CMP_LTZ];

    assign pc4    = pc_d + XLEN'(4);
    assign br_tgt = pc4 + {sext_imm[XLEN-3:0], 2'b00};
    assign j_tgt  = {pc4[XLEN-1:28], instr_d[25:0], 2'b00};
    assign sel    = npc_sel_e'(npc_sel);

    always_comb begin
        taken = 1'b0;
        tgt   = br_tgt;
        case (sel)
            NPC_BEQ:       taken = cmp[CMP_EQ];
            NPC_BNE:       taken = ~cmp[CMP_EQ];
            NPC_BLEZ:      taken = cmp[CMP_LEZ];
            NPC_BGTZ:      taken = cmp[CMP_GTZ];
            NPC_BLTZ_BGEZ: taken = instr_d[16] ? cmp[CMP_GEZ] : cmp[CMP_LTZ];
            NPC_J:         begin taken = 1'b1; tgt = j_tgt; end
            NPC_JR:        begin taken = 1'b1; tgt = op_a; end
            default:       taken = 1'b0;
        endcase
    end

    assign br_taken = valid_d & taken;
    assign npc      = br_taken ? tgt : pc4;

    // an upstream exception takes precedence over the illegal-instruction verdict
    assign exc = (!legal_ir && exc_d == '0) ? EXCW'(EXC_RI) : exc_d;

    always_comb begin
        rs_e_d    = rs_e_q;
        rt_e_d    = rt_e_q;
        ext_e_d   = ext_e_q;
        pc_e_d    = pc_e_q;
        instr_e_d = instr_e_q;
        exc_e_d   = exc_e_q;
        valid_e_d = valid_e_q;
        if (flush || (!hold_e && bubble_e)) begin
            rs_e_d    = '0;
            rt_e_d    = '0;
            ext_e_d   = '0;
            pc_e_d    = '0;
            instr_e_d = '0;
            exc_e_d   = '0;
            valid_e_d = 1'b0;
        end else if (!hold_e) begin
            rs_e_d    = op_a;
            rt_e_d    = op_b;
            ext_e_d   = ext_val;
            pc_e_d    = pc_d;
            instr_e_d = instr_d;
            exc_e_d   = exc;
            valid_e_d = valid_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_e_q    <= '0;
            rt_e_q    <= '0;
            ext_e_q   <= '0;
            pc_e_q    <= '0;
            instr_e_q <= '0;
            exc_e_q   <= '0;
            valid_e_q <= 1'b0;
        end else begin
            rs_e_q    <= rs_e_d;
            rt_e_q    <= rt_e_d;
            ext_e_q   <= ext_e_d;
            pc_e_q    <= pc_e_d;
            instr_e_q <= instr_e_d;
            exc_e_q   <= exc_e_d;
            valid_e_q <= valid_e_d;
        end
    end

    assign rs_e    = rs_e_q;
    assign rt_e    = rt_e_q;
    assign ext_e   = ext_e_q;
    assign pc_e    = pc_e_q;
    assign instr_e = instr_e_q;
    assign exc_e   = exc_e_q;
    assign valid_e = valid_e_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed vectors; E-register expectations go through a scoreboard queue
// drained by a negedge monitor, combinational npc/br_taken are checked inline.
module tb_decode_pipe;

    typedef struct packed {
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [4:0]  exc_d;
    logic        legal_ir;
    logic [1:0]  ext_op;
    logic [2:0]  npc_sel;
    logic [95:0] fwd_data;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
    logic        wr_en_w;
    logic [4:0]  wr_addr_w;
    logic [31:0] wr_data_w;
    logic        hold_e, bubble_e, flush;
    logic [31:0] npc;
    logic        br_taken;
    logic [31:0] rs_e, rt_e, ext_e, pc_e, instr_e;
    logic [4:0]  exc_e;
    logic        valid_e;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    string sb_nm[$];

    decode_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .valid_d   (valid_d),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .exc_d     (exc_d),
        .legal_ir  (legal_ir),
        .ext_op    (ext_op),
        .npc_sel   (npc_sel),
        .fwd_data  (fwd_data),
        .fwd_sel_rs(fwd_sel_rs),
        .fwd_sel_rt(fwd_sel_rt),
        .wr_en_w   (wr_en_w),
        .wr_addr_w (wr_addr_w),
        .wr_data_w (wr_data_w),
        .hold_e    (hold_e),
        .bubble_e  (bubble_e),
        .flush     (flush),
        .npc       (npc),
        .br_taken  (br_taken),
        .rs_e      (rs_e),
        .rt_e      (rt_e),
        .ext_e     (ext_e),
        .pc_e      (pc_e),
        .instr_e   (instr_e),
        .exc_e     (exc_e),
        .valid_e   (valid_e)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e, g;
            string nm;
            e  = sb.pop_front();
            nm = sb_nm.pop_front();
            g  = {rs_e, rt_e, ext_e, pc_e, instr_e, exc_e, valid_e};
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL %s: got rs=%h rt=%h ext=%h pc=%h instr=%h exc=%0d v=%b, exp rs=%h rt=%h ext=%h pc=%h instr=%h exc=%0d v=%b",
                         nm, g.rs, g.rt, g.ext, g.pc, g.instr, g.exc, g.v,
                         e.rs, e.rt, e.ext, e.pc, e.instr, e.exc, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {6'h00, rs, rt, imm};
    endfunction

    function automatic exp_t ex(input logic [31:0] rs, rt, ext, pc, instr, input logic [4:0] exc, input logic v);
        return {rs, rt, ext, pc, instr, exc, v};
    endfunction

    task automatic idle();
        valid_d    = 1'b0;
        instr_d    = '0;
        pc_d       = '0;
        exc_d      = '0;
        legal_ir   = 1'b1;
        ext_op     = '0;
        npc_sel    = '0;
        fwd_data   = '0;
        fwd_sel_rs = '0;
        fwd_sel_rt = '0;
        wr_en_w    = 1'b0;
        wr_addr_w  = '0;
        wr_data_w  = '0;
        hold_e     = 1'b0;
        bubble_e   = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic cyc(input string nm, input exp_t e);
        sb.push_back(e);
        sb_nm.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, exp %h", nm, got, exp);
        end
    endtask

    task automatic chk_npc(input string nm, input logic [31:0] exp_npc, input logic exp_br);
        #1;
        chk({nm, "_npc"}, npc, exp_npc);
        chk({nm, "_br"}, {31'b0, br_taken}, {31'b0, exp_br});
    endtask

    initial begin
        exp_t a;
        reset      = 1'b0;
        valid_d    = 1'b1;
        instr_d    = $urandom;
        pc_d       = $urandom;
        exc_d      = 5'($urandom);
        legal_ir   = 1'($urandom);
        ext_op     = 2'($urandom);
        npc_sel    = 3'($urandom);
        fwd_data   = {$urandom, $urandom, $urandom};
        fwd_sel_rs = 2'($urandom);
        fwd_sel_rt = 2'($urandom);
        wr_en_w    = 1'b1;
        wr_addr_w  = 5'd5;
        wr_data_w  = $urandom | 32'h1;
        hold_e     = 1'($urandom);
        bubble_e   = 1'($urandom);
        flush      = 1'($urandom);
        #1;
        cyc("reset0", '0);
        cyc("reset1", '0);
        reset = 1'b1;
        idle();

        valid_d = 1'b1; instr_d = mk(5, 0, 16'h0); pc_d = 32'h100;
        cyc("read_r5", ex(0, 0, 0, 32'h100, mk(5, 0, 16'h0), 0, 1));

        idle(); valid_d = 1'b1; wr_en_w = 1'b1; wr_addr_w = 5'd3; wr_data_w = 32'h1234;
        instr_d = mk(3, 0, 16'h0010); ext_op = 2'd1; pc_d = 32'h104;
        cyc("wt_r3", ex(32'h1234, 0, 32'h10, 32'h104, mk(3, 0, 16'h0010), 0, 1));

        idle(); valid_d = 1'b1; wr_en_w = 1'b1; wr_addr_w = 5'd0; wr_data_w = 32'hFFFF;
        instr_d = mk(0, 0, 16'h0); pc_d = 32'h108;
        cyc("wr_r0_same", ex(0, 0, 0, 32'h108, mk(0, 0, 16'h0), 0, 1));

        idle(); valid_d = 1'b1; instr_d = mk(0, 3, 16'h8000); ext_op = 2'd1; pc_d = 32'h10C;
        cyc("rd_r0_r3", ex(0, 32'h1234, 32'hFFFF8000, 32'h10C, mk(0, 3, 16'h8000), 0, 1));

        idle(); wr_en_w = 1'b1; wr_addr_w = 5'd7; wr_data_w = 32'd7;
        cyc("wr_r7", '0);
        idle(); wr_en_w = 1'b1; wr_addr_w = 5'd8; wr_data_w = 32'd8;
        cyc("wr_r8", '0);

        idle(); valid_d = 1'b1; npc_sel = 3'd1; instr_d = mk(9, 7, 16'hFFFE);
        fwd_sel_rs = 2'd1; fwd_data[31:0] = 32'd7; pc_d = 32'h3000; ext_op = 2'd1;
        chk_npc("beq_taken", 32'h2FFC, 1'b1);
        cyc("beq_taken", ex(7, 7, 32'hFFFFFFFE, 32'h3000, mk(9, 7, 16'hFFFE), 0, 1));

        instr_d = mk(9, 8, 16'hFFFE);
        chk_npc("beq_not", 32'h3004, 1'b0);
        cyc("beq_not", ex(7, 8, 32'hFFFFFFFE, 32'h3000, mk(9, 8, 16'hFFFE), 0, 1));

        npc_sel = 3'd2;
        chk_npc("bne_taken", 32'h2FFC, 1'b1);
        cyc("bne_taken", ex(7, 8, 32'hFFFFFFFE, 32'h3000, mk(9, 8, 16'hFFFE), 0, 1));

        npc_sel = 3'd1; instr_d = mk(9, 7, 16'hFFFE); valid_d = 1'b0;
        #1;
        chk("beq_invalid_br", {31'b0, br_taken}, 32'd0);
        cyc("beq_invalid", ex(7, 7, 32'hFFFFFFFE, 32'h3000, mk(9, 7, 16'hFFFE), 0, 0));

        idle(); valid_d = 1'b1; npc_sel = 3'd7; fwd_sel_rs = 2'd2; fwd_data[63:32] = 32'h4180;
        instr_d = mk(0, 0, 16'h0); pc_d = 32'h500;
        chk_npc("jr", 32'h4180, 1'b1);
        cyc("jr", ex(32'h4180, 0, 0, 32'h500, mk(0, 0, 16'h0), 0, 1));

        idle(); valid_d = 1'b1; npc_sel = 3'd6; instr_d = {6'h02, 26'h0000100};
        pc_d = 32'h3000; ext_op = 2'd2;
        chk_npc("j", 32'h400, 1'b1);
        cyc("j_lui", ex(0, 0, 32'h01000000, 32'h3000, {6'h02, 26'h0000100}, 0, 1));

        idle(); valid_d = 1'b1; npc_sel = 3'd3; fwd_sel_rs = 2'd3; fwd_data[95:64] = 32'hFFFFFFFF;
        instr_d = mk(4, 0, 16'h4); pc_d = 32'h200;
        chk_npc("blez", 32'h214, 1'b1);
        cyc("blez", ex(32'hFFFFFFFF, 0, 4, 32'h200, mk(4, 0, 16'h4), 0, 1));

        npc_sel = 3'd4;
        chk_npc("bgtz", 32'h204, 1'b0);
        cyc("bgtz", ex(32'hFFFFFFFF, 0, 4, 32'h200, mk(4, 0, 16'h4), 0, 1));

        npc_sel = 3'd5; instr_d = mk(4, 1, 16'h4);
        chk_npc("bgez", 32'h204, 1'b0);
        cyc("bgez", ex(32'hFFFFFFFF, 0, 4, 32'h200, mk(4, 1, 16'h4), 0, 1));

        instr_d = mk(4, 0, 16'h4);
        chk_npc("bltz", 32'h214, 1'b1);
        cyc("bltz", ex(32'hFFFFFFFF, 0, 4, 32'h200, mk(4, 0, 16'h4), 0, 1));

        idle(); valid_d = 1'b1; legal_ir = 1'b0; instr_d = mk(0, 0, 16'h0); pc_d = 32'h600;
        cyc("exc_ri", ex(0, 0, 0, 32'h600, mk(0, 0, 16'h0), 5'd10, 1));
        exc_d = 5'd4; pc_d = 32'h604;
        cyc("exc_up", ex(0, 0, 0, 32'h604, mk(0, 0, 16'h0), 5'd4, 1));

        a = ex(32'h1234, 7, 32'h42, 32'h700, mk(3, 7, 16'h0042), 0, 1);
        idle(); valid_d = 1'b1; instr_d = mk(3, 7, 16'h0042); pc_d = 32'h700;
        cyc("load_a", a);
        idle(); hold_e = 1'b1; valid_d = 1'b1; instr_d = mk(8, 8, 16'h0099); pc_d = 32'h800;
        cyc("hold1", a);
        cyc("hold2", a);
        idle(); bubble_e = 1'b1; valid_d = 1'b1; instr_d = mk(8, 8, 16'h1); pc_d = 32'h804;
        cyc("bubble", '0);
        idle(); valid_d = 1'b1; instr_d = mk(3, 7, 16'h0042); pc_d = 32'h700;
        cyc("reload_a", a);
        flush = 1'b1; hold_e = 1'b1;
        cyc("flush_hold", '0);

        idle(); valid_d = 1'b1; instr_d = mk(3, 7, 16'h0042); pc_d = 32'h700;
        cyc("load_a2", a);
        reset = 1'b0;
        #1;
        chk("async_valid", {31'b0, valid_e}, 32'd0);
        chk("async_rs", rs_e, 32'd0);
        cyc("in_reset", '0);
        reset = 1'b1;
        idle(); valid_d = 1'b1; instr_d = mk(3, 7, 16'h0); pc_d = 32'h900;
        cyc("grf_cleared", ex(0, 0, 0, 32'h900, mk(3, 7, 16'h0), 0, 1));

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
